// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris board blocks.
// Holds the line-clear FSM state encoding, the base point values for
// one to four (or more) cleared lines, and the default board geometry
// used by the line-clear engine and its neighbours (merge, color_mapper).
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    DONE
  } state_e;

  localparam int PTS_1 = 40;
  localparam int PTS_2 = 100;
  localparam int PTS_3 = 300;
  localparam int PTS_4 = 1200;

  localparam int         DEF_ROWS      = 22;
  localparam int         DEF_COLS      = 12;
  localparam logic [11:0] DEF_WALL_MASK = 12'h801;

endpackage

// File: rtl/line_clear_engine_if.sv
// Request/result bundle of the line-clear engine.
//   start         : one-cycle request, board_in sampled on the same edge
//   board_in      : board snapshot, row 0 is the top
//   level         : current level, scales the points awarded
//   clear_stats   : synchronous clear of total_lines and score
//   busy          : operation in progress
//   done          : one-cycle pulse, board_out/lines_cleared valid from here
//   board_out     : compacted board, held until the next done
//   lines_cleared : rows removed by the last operation
//   total_lines   : saturating running line total
//   score         : saturating running score
// master drives requests (piece-merge side), slave is the engine.
interface line_clear_engine_if
  import tetris_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int SCORE_W = 20
);

  localparam int CW = $clog2(ROWS + 1);

  logic                start;
  logic [COLS-1:0]     board_in [ROWS];
  logic [3:0]          level;
  logic                clear_stats;
  logic                busy;
  logic                done;
  logic [COLS-1:0]     board_out [ROWS];
  logic [CW-1:0]       lines_cleared;
  logic [15:0]         total_lines;
  logic [SCORE_W-1:0]  score;

  modport master (
    output start, board_in, level, clear_stats,
    input  busy, done, board_out, lines_cleared, total_lines, score
  );

  modport slave (
    input  start, board_in, level, clear_stats,
    output busy, done, board_out, lines_cleared, total_lines, score
  );

endinterface

// File: rtl/line_score_accum.sv
// Line and score statistics for the line-clear engine.
// Converts a cleared-line count into points scaled by (level+1) and adds
// it, with saturation, to the running score; also keeps a saturating
// total of cleared lines. clear_i has priority over update_i.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   cnt_i           : lines removed by the finishing operation
//   level_i         : current level
//   update_i        : one-cycle strobe to accumulate cnt_i
//   clear_i         : zero both accumulators
//   total_lines_o   : running line total (clamps at 16'hFFFF)
//   score_o         : running score (clamps at all ones)
module line_score_accum
  import tetris_pkg::*;
#(
  parameter int CW      = 5,
  parameter int SCORE_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CW-1:0]      cnt_i,
  input  logic [3:0]         level_i,
  input  logic               update_i,
  input  logic               clear_i,
  output logic [15:0]        total_lines_o,
  output logic [SCORE_W-1:0] score_o
);

  localparam int PW = SCORE_W + 4;

  logic [PW-1:0]      pts;
  logic [PW-1:0]      prod;
  logic [PW:0]        scoreSum;
  logic [16:0]        linesSum;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]        total_q, total_d;

  // Points lookup, level scaling and saturating next values; a clear
  // in the same cycle as an update discards the update.
  always_comb begin
    pts      = '0;
    if (cnt_i == CW'(1))      pts = PW'(PTS_1);
    else if (cnt_i == CW'(2)) pts = PW'(PTS_2);
    else if (cnt_i == CW'(3)) pts = PW'(PTS_3);
    else if (cnt_i != '0)     pts = PW'(PTS_4);
    prod     = pts * (PW'(level_i) + PW'(1));
    scoreSum = (PW+1)'(score_q) + (PW+1)'(prod);
    linesSum = 17'(total_q) + 17'(cnt_i);
    score_d  = score_q;
    total_d  = total_q;
    if (clear_i) begin
      score_d = '0;
      total_d = '0;
    end else if (update_i) begin
      score_d = (|scoreSum[PW:SCORE_W]) ? '1 : scoreSum[SCORE_W-1:0];
      total_d = linesSum[16] ? 16'hFFFF : linesSum[15:0];
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      total_q <= '0;
    end else begin
      score_q <= score_d;
      total_q <= total_d;
    end
  end

  assign total_lines_o = total_q;
  assign score_o       = score_q;

endmodule

// File: rtl/line_clear_engine.sv
// Sequential line-clear stage. On start it latches the board, scans the
// playfield bottom-up one row per clock, drops full rows and compacts the
// survivors downward, refills the freed top rows with wall-only rows, and
// then publishes the new board with a one-cycle done pulse.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : line_clear_engine_if slave (request, result, statistics)
module line_clear_engine
  import tetris_pkg::*;
#(
  parameter int              ROWS       = DEF_ROWS,
  parameter int              COLS       = DEF_COLS,
  parameter logic [COLS-1:0] WALL_MASK  = COLS'(DEF_WALL_MASK),
  parameter int              FLOOR_ROWS = 1,
  parameter int              SCORE_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  line_clear_engine_if.slave bus
);

  localparam int N  = ROWS - FLOOR_ROWS;
  localparam int IW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);

  state_e          state_q, state_d;
  logic [COLS-1:0] rowbuf_q [ROWS];
  logic [COLS-1:0] rowbuf_d [ROWS];
  logic [COLS-1:0] board_out_q [ROWS];
  logic [COLS-1:0] board_out_d [ROWS];
  logic [IW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   lines_q, lines_d;
  logic            done_q, done_d;
  logic            rowFull;
  logic [15:0]     totalLines;
  logic [SCORE_W-1:0] scoreVal;

  // Wall columns count as filled, so a row is full when only the wall
  // bits are missing from an all-ones pattern.
  assign rowFull = ((rowbuf_q[rd_q] | WALL_MASK) == '1);

  // Next-state and datapath. wr trails rd by the number of rows removed
  // so far; after the scan, rows 0..wr are the ones vacated by removal.
  // A start during the done pulse is not accepted.
  always_comb begin
    state_d     = state_q;
    rowbuf_d    = rowbuf_q;
    board_out_d = board_out_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          rowbuf_d = bus.board_in;
          rd_d     = IW'(N - 1);
          wr_d     = IW'(N - 1);
          cnt_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (rowFull) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          rowbuf_d[wr_q] = rowbuf_q[rd_q];
          wr_d           = wr_q - IW'(1);
        end
        rd_d = rd_q - IW'(1);
        if (rd_q == '0) state_d = FILL;
      end
      FILL: begin
        for (int r = 0; r < N; r++) begin
          if ((cnt_q != '0) && (IW'(r) <= wr_q)) rowbuf_d[r] = WALL_MASK;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d      = 1'b1;
        board_out_d = rowbuf_q;
        lines_d     = cnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        rowbuf_q[r]    <= '0;
        board_out_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      lines_q     <= lines_d;
      done_q      <= done_d;
      rowbuf_q    <= rowbuf_d;
      board_out_q <= board_out_d;
    end
  end

  line_score_accum #(
    .CW      (CW),
    .SCORE_W (SCORE_W)
  ) u_accum (
    .clk           (clk),
    .reset         (reset),
    .cnt_i         (cnt_q),
    .level_i       (bus.level),
    .update_i      (state_q == DONE),
    .clear_i       (bus.clear_stats),
    .total_lines_o (totalLines),
    .score_o       (scoreVal)
  );

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.board_out     = board_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.total_lines   = totalLines;
  assign bus.score         = scoreVal;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed testbench for line_clear_engine with default parameters
// (22 rows, 12 columns, walls 12'h801, one floor row, 20-bit score).
module tb_line_clear_engine;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [11:0] stim [22];
  logic [11:0] expBoard [22];

  line_clear_engine_if bus ();

  line_clear_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait, bounded, for its done pulse.
  // lat counts clock edges after the edge that sampled start.
  task automatic run_op(input logic [3:0] lvl, output int lat, output bit timedOut);
    if (bus.done) begin
      @(posedge clk); #1;
    end
    bus.board_in = stim;
    bus.level    = lvl;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 0;
    timedOut  = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat      = i;
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    bus.clear_stats = 1'b1;
    @(posedge clk); #1;
    bus.clear_stats = 1'b0;
  endtask

  // Outputs after reset.
  task automatic test_reset();
    int bad;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.lines_cleared !== 5'd0) begin errors++; $display("[TB] FAIL reset_lines got %0d want 0", bus.lines_cleared); end
    checks++; if (bus.total_lines !== 16'd0) begin errors++; $display("[TB] FAIL reset_total got %0d want 0", bus.total_lines); end
    checks++; if (bus.score !== 20'd0) begin errors++; $display("[TB] FAIL reset_score got %0d want 0", bus.score); end
    bad = 0;
    for (int r = 0; r < 22; r++) if (bus.board_out[r] !== 12'h000) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL reset_board got %0d nonzero rows want 0", bad); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One full row at the bottom of the playfield.
  task automatic test_single_clear();
    int lat; bit to;
    for (int r = 0; r < 22; r++) stim[r] = 12'h801;
    stim[0] = 12'h000; stim[20] = 12'hFFF; stim[21] = 12'hFFF;
    run_op(4'd0, lat, to);
    checks++; if (to || lat != 23) begin errors++; $display("[TB] FAIL single_latency got %0d (timeout %0b) want 23", lat, to); end
    checks++; if (bus.lines_cleared !== 5'd1) begin errors++; $display("[TB] FAIL single_lines got %0d want 1", bus.lines_cleared); end
    checks++; if (bus.board_out[20] !== 12'h801) begin errors++; $display("[TB] FAIL single_row20 got %h want 801", bus.board_out[20]); end
    checks++; if (bus.board_out[0] !== 12'h801) begin errors++; $display("[TB] FAIL single_row0 got %h want 801", bus.board_out[0]); end
    checks++; if (bus.board_out[1] !== 12'h000) begin errors++; $display("[TB] FAIL single_row1 got %h want 000", bus.board_out[1]); end
    checks++; if (bus.board_out[21] !== 12'hFFF) begin errors++; $display("[TB] FAIL single_floor got %h want fff", bus.board_out[21]); end
    checks++; if (bus.score !== 20'd40) begin errors++; $display("[TB] FAIL single_score got %0d want 40", bus.score); end
    checks++; if (bus.total_lines !== 16'd1) begin errors++; $display("[TB] FAIL single_total got %0d want 1", bus.total_lines); end
  endtask

  // Four full rows at level 2, after clearing the statistics; start is
  // also pulsed during the done cycle and must be dropped.
  task automatic test_quad_clear();
    int lat; bit to; int bad;
    pulse_clear();
    checks++; if (bus.score !== 20'd0) begin errors++; $display("[TB] FAIL clear_score got %0d want 0", bus.score); end
    for (int r = 0; r < 22; r++) stim[r] = 12'h801;
    for (int r = 17; r <= 20; r++) stim[r] = 12'hFFF;
    stim[16] = 12'h803; stim[21] = 12'hFFF;
    run_op(4'd2, lat, to);
    checks++; if (to || lat != 23) begin errors++; $display("[TB] FAIL quad_latency got %0d (timeout %0b) want 23", lat, to); end
    checks++; if (bus.lines_cleared !== 5'd4) begin errors++; $display("[TB] FAIL quad_lines got %0d want 4", bus.lines_cleared); end
    checks++; if (bus.board_out[20] !== 12'h803) begin errors++; $display("[TB] FAIL quad_row20 got %h want 803", bus.board_out[20]); end
    bad = 0;
    for (int r = 0; r < 20; r++) if (bus.board_out[r] !== 12'h801) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL quad_rows0_19 got %0d rows differing want 0", bad); end
    checks++; if (bus.score !== 20'd3600) begin errors++; $display("[TB] FAIL quad_score got %0d want 3600", bus.score); end
    checks++; if (bus.total_lines !== 16'd4) begin errors++; $display("[TB] FAIL quad_total got %0d want 4", bus.total_lines); end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL done_cycle_start busy got %b want 0", bus.busy); end
  endtask

  // Board with non-adjacent full rows 10 and 15 and marked survivors.
  task automatic build_split();
    for (int r = 0; r < 22; r++) stim[r] = 12'h801;
    stim[0] = 12'h000; stim[9] = 12'h845; stim[10] = 12'hFFF;
    stim[11] = 12'h8A1; stim[15] = 12'hFFF; stim[16] = 12'h811; stim[21] = 12'hFFF;
    for (int r = 0; r < 22; r++) expBoard[r] = 12'h801;
    expBoard[2] = 12'h000; expBoard[11] = 12'h845; expBoard[12] = 12'h8A1;
    expBoard[16] = 12'h811; expBoard[21] = 12'hFFF;
  endtask

  task automatic test_split_clear();
    int lat; bit to; int bad;
    build_split();
    run_op(4'd0, lat, to);
    checks++; if (to || lat != 23) begin errors++; $display("[TB] FAIL split_latency got %0d (timeout %0b) want 23", lat, to); end
    checks++; if (bus.lines_cleared !== 5'd2) begin errors++; $display("[TB] FAIL split_lines got %0d want 2", bus.lines_cleared); end
    bad = 0;
    for (int r = 0; r < 22; r++) if (bus.board_out[r] !== expBoard[r]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL split_board got %0d rows differing want 0", bad); end
    checks++; if (bus.score !== 20'd3700) begin errors++; $display("[TB] FAIL split_score got %0d want 3700", bus.score); end
  endtask

  // Second start while busy must be ignored.
  task automatic test_back_to_back();
    int doneCount; int firstLat; int bad;
    build_split();
    @(posedge clk); #1;
    bus.board_in = stim; bus.level = 4'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got %b want 1", bus.busy); end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    doneCount = 0; firstLat = 0;
    for (int i = 6; i <= 70; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        doneCount++;
        if (firstLat == 0) firstLat = i;
      end
    end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL b2b_done_count got %0d want 1", doneCount); end
    checks++; if (firstLat != 23) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 23", firstLat); end
    bad = 0;
    for (int r = 0; r < 22; r++) if (bus.board_out[r] !== expBoard[r]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b2b_board got %0d rows differing want 0", bad); end
    checks++; if (bus.score !== 20'd3800) begin errors++; $display("[TB] FAIL b2b_score got %0d want 3800", bus.score); end
    checks++; if (bus.total_lines !== 16'd8) begin errors++; $display("[TB] FAIL b2b_total got %0d want 8", bus.total_lines); end
  endtask

  // No full rows: board passes through, no points at level 3.
  task automatic test_empty_board();
    int lat; bit to; int bad;
    for (int r = 0; r < 21; r++) stim[r] = 12'(r * 5) | 12'h400;
    stim[21] = 12'hFFF;
    run_op(4'd3, lat, to);
    checks++; if (to || bus.lines_cleared !== 5'd0) begin errors++; $display("[TB] FAIL empty_lines got %0d (timeout %0b) want 0", bus.lines_cleared, to); end
    bad = 0;
    for (int r = 0; r < 22; r++) if (bus.board_out[r] !== stim[r]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL empty_board got %0d rows differing want 0", bad); end
    checks++; if (bus.score !== 20'd3800) begin errors++; $display("[TB] FAIL empty_score got %0d want 3800", bus.score); end
  endtask

  // Reset in the middle of the scan aborts without a done.
  task automatic test_abort_reset();
    int bad; int doneSeen;
    for (int r = 0; r < 22; r++) stim[r] = 12'h801;
    stim[20] = 12'hFFF;
    @(posedge clk); #1;
    bus.board_in = stim; bus.level = 4'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
    checks++; if (bus.score !== 20'd0 || bus.total_lines !== 16'd0) begin errors++; $display("[TB] FAIL abort_stats got score %0d total %0d want 0 0", bus.score, bus.total_lines); end
    bad = 0;
    for (int r = 0; r < 22; r++) if (bus.board_out[r] !== 12'h000) bad++;
    checks++; if (bad != 0 || bus.lines_cleared !== 5'd0) begin errors++; $display("[TB] FAIL abort_outputs got %0d nonzero rows lines %0d want 0 0", bad, bus.lines_cleared); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) doneSeen++;
    end
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL abort_done got %0d pulses want 0", doneSeen); end
  endtask

  // clear_stats on the same edge as the statistics update wins.
  task automatic test_clear_coincide();
    for (int r = 0; r < 22; r++) stim[r] = 12'h801;
    stim[20] = 12'hFFF;
    bus.board_in = stim; bus.level = 4'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (22) @(posedge clk);
    #1 bus.clear_stats = 1'b1;
    @(posedge clk); #1;
    bus.clear_stats = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL coincide_done got %b want 1", bus.done); end
    checks++; if (bus.score !== 20'd0 || bus.total_lines !== 16'd0) begin errors++; $display("[TB] FAIL coincide_stats got score %0d total %0d want 0 0", bus.score, bus.total_lines); end
    checks++; if (bus.lines_cleared !== 5'd1) begin errors++; $display("[TB] FAIL coincide_lines got %0d want 1", bus.lines_cleared); end
  endtask

  // Repeated all-full boards at level 15 (19200 points each) drive the
  // score into saturation after 55 operations.
  task automatic test_saturation();
    int lat; bit to; int timeouts; int bad;
    pulse_clear();
    for (int r = 0; r < 21; r++) stim[r] = (r % 2 == 0) ? 12'hFFF : 12'h7FE;
    stim[21] = 12'h000;
    timeouts = 0;
    for (int op = 1; op <= 56; op++) begin
      run_op(4'd15, lat, to);
      if (to) timeouts++;
      if (op == 1) begin
        bad = 0;
        for (int r = 0; r < 21; r++) if (bus.board_out[r] !== 12'h801) bad++;
        checks++; if (bad != 0 || bus.board_out[21] !== 12'h000) begin errors++; $display("[TB] FAIL allfull_board got %0d rows differing floor %h want 0 000", bad, bus.board_out[21]); end
        checks++; if (bus.lines_cleared !== 5'd21) begin errors++; $display("[TB] FAIL allfull_lines got %0d want 21", bus.lines_cleared); end
      end
      if (op == 54) begin
        checks++; if (bus.score !== 20'd1036800) begin errors++; $display("[TB] FAIL sat_pre got %0d want 1036800", bus.score); end
      end
      if (op == 55) begin
        checks++; if (bus.score !== 20'hFFFFF) begin errors++; $display("[TB] FAIL sat_clamp got %h want fffff", bus.score); end
      end
    end
    checks++; if (bus.score !== 20'hFFFFF) begin errors++; $display("[TB] FAIL sat_hold got %h want fffff", bus.score); end
    checks++; if (bus.total_lines !== 16'd1176) begin errors++; $display("[TB] FAIL sat_total got %0d want 1176", bus.total_lines); end
    checks++; if (timeouts != 0) begin errors++; $display("[TB] FAIL sat_timeouts got %0d want 0", timeouts); end
  endtask

  // Test sequence.
  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.level       = 4'd0;
    bus.clear_stats = 1'b0;
    for (int r = 0; r < 22; r++) stim[r] = 12'h000;
    bus.board_in = stim;
    test_reset();
    test_single_clear();
    test_quad_clear();
    test_split_clear();
    test_back_to_back();
    test_empty_board();
    test_abort_reset();
    test_clear_coincide();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Parametrised, sequential successor to the single-cycle line-clear stage.
- Latches a board snapshot on a start pulse and scans it bottom-up, one row per clock.
- Removes full rows and compacts the remaining rows downward, then refills the top with empty (wall-only) rows.
- Reports lines cleared and keeps running line/score statistics. Sits between the piece-merge logic and color_mapper; triggered once per piece lock.

Parameters:
- ROWS, 22, total board rows; row 0 is the top.
- COLS, 12, bits per row; bit i is column i.
- WALL_MASK, 12'h801, column bits that are permanent walls; forced to 1 when testing fullness and kept in refilled rows.
- FLOOR_ROWS, 1, bottom rows excluded from scanning and passed through unchanged.
- SCORE_W, 20, score accumulator width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; board_in sampled on the same edge.
- board_in  in  [COLS-1:0] x ROWS (unpacked)  board snapshot.
- level  in  4  current level, used for score multiplier.
- clear_stats  in  1  synchronous clear of total_lines and score.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; board_out and lines_cleared are valid from this cycle.
- board_out  out  [COLS-1:0] x ROWS  compacted board, held until the next done.
- lines_cleared  out  $clog2(ROWS+1)  rows removed by the last operation.
- total_lines  out  16  saturating running total.
- score  out  SCORE_W  saturating running score.

Behaviour:
- Reset state: FSM=IDLE; busy=0, done=0, board_out all 0, lines_cleared=0, total_lines=0, score=0. Reset mid-operation aborts immediately; no done is produced.
- Let N = ROWS-FLOOR_ROWS.
- States: IDLE, SCAN, FILL, DONE.
- IDLE -> SCAN:
  - On start, copy board_in to an internal buffer.
  - Set rd=wr=N-1 and cnt=0.
  - start is ignored while busy=1.
- SCAN, once per cycle:
  - A row is full when (buf[rd] | WALL_MASK) is all ones.
  - Full row: cnt++, rd--.
  - Otherwise: buf[wr] <= buf[rd], wr--, rd--.
  - After processing rd==0 (N cycles), go to FILL.
- FILL, one cycle: every row index <= wr (only when cnt > 0) <= WALL_MASK. Floor rows are never modified.
- DONE, one cycle:
  - done=1; board_out <= buf; lines_cleared <= cnt.
  - total_lines += cnt.
  - score += P(cnt) * (level+1), where P(0)=0, P(1)=40, P(2)=100, P(3)=300, P(cnt>=4)=1200.
  - Then return to IDLE.
- Latency: start sampled at edge k; done high in the cycle following edge k+N+2, i.e. N+2 cycles after start (23 with default parameters).
- Saturation: total_lines clamps at 16'hFFFF; score clamps at 2^SCORE_W-1. Products are computed in SCORE_W+4 bits before the clamp.
- clear_stats: zeroes total_lines and score on the next edge. When it coincides with the DONE update, clear wins and the increment is dropped. lines_cleared and board_out are unaffected.
- start asserted in the DONE cycle is ignored; the earliest accepted start is the following IDLE cycle.
- All-full board: every scanned row is removed, cnt=N, and all N rows become WALL_MASK.
- Empty board: cnt=0; board_out equals board_in.

Decomposition:
- Package tetris_pkg holds:
  - the state enum (IDLE, SCAN, FILL, DONE);
  - the constants PTS_1=40, PTS_2=100, PTS_3=300, PTS_4=1200;
  - the default ROWS, COLS and WALL_MASK values, shared with the other board blocks.
- Sub-module line_score_accum: takes cnt, level, an update strobe and clear_stats. It owns the points lookup, the multiply, and both saturating accumulators.

Test Plan:
- Default parameters, board with rows 1..20 = 12'h801 and row 20 = 12'hFFF, start -> done exactly 23 cycles later; lines_cleared=1; row 20 out = 12'h801; row 0 = 12'h801; score=40 at level 0.
- Rows 17..20 = 12'hFFF, row 16 = 12'h803, level=2 -> lines_cleared=4; row 20 out = 12'h803; rows 0..19 = 12'h801; score=3600; total_lines=4.
- Non-adjacent full rows 10 and 15 with distinct patterns in rows 9, 11 and 16 -> survivors keep relative order shifted down correctly; lines_cleared=2; score +100.
- Pulse start again while busy at cycle 5 -> ignored; exactly one done, and result identical to the single-start run.
- Assert reset at SCAN cycle 10 -> done never pulses; all outputs 0. Then clear_stats coinciding with done -> score=0, total_lines=0; lines_cleared still reflects cnt.
- Preload score near 2^20-1 via repeated 4-line clears at level 15 -> score saturates at 20'hFFFFF and does not wrap.
